// File: rtl/pe_nway_mux_pipe.sv
// N-way operand selector with fixed-select or round-robin grant and a registered output stage.
// Latency: 1 cycle from input handshake to out_valid; 1 transfer/cycle with out_ready high.
// Backpressure: single register, no skid; in_ready is low whenever the held output is stalled.
module pe_nway_mux_pipe #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SEL_W-1:0] rr_ptr;
    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_dat;

    assign load_en = ~out_valid | out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // Walk the search order backwards so the last hit is the first channel after rr_ptr.
            for (int k = N; k >= 1; k--) begin
                if (in_valid[(int'(rr_ptr) + k) % N]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'((int'(rr_ptr) + k) % N);
                end
            end
        end
    end

    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_dat = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = !reset && load_en && grant_vld && (grant_idx == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= SEL_W'(N - 1);
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid <= 1'b1;
                out_data  <= grant_dat;
                out_src   <= grant_idx;
                // Fixed-mode traffic leaves the round-robin pointer alone to keep fairness intact.
                if (mode) begin
                    rr_ptr <= grant_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_nway_mux_pipe.sv
// Bench for pe_nway_mux_pipe: directed scenarios plus random traffic against a behavioural model.
module tb_pe_nway_mux_pipe;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_src;
    logic               out_valid;
    logic               out_ready;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic             m_vld;
    logic [WIDTH-1:0] m_dat;
    int               m_src;
    int               m_ptr;
    logic [N-1:0]     rdy_seen;

    always #5 clk = ~clk;

    pe_nway_mux_pipe #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (!mode) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_ch(input int i, input logic [WIDTH-1:0] d);
        in_data[i*WIDTH +: WIDTH] = d;
    endtask

    // One clock: check in_ready against the model, clock, advance the model, check outputs.
    task automatic cycle(input string tag);
        int           g;
        logic         load;
        logic [N-1:0] exp_rdy;
        #1;
        g       = model_grant();
        load    = !m_vld || out_ready;
        exp_rdy = '0;
        if (!reset && load && g >= 0) exp_rdy[g] = 1'b1;
        rdy_seen = in_ready;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (reset) begin
            m_vld = 1'b0; m_dat = '0; m_src = 0; m_ptr = N - 1;
        end else if (load) begin
            if (g >= 0) begin
                m_vld = 1'b1;
                m_dat = in_data[g*WIDTH +: WIDTH];
                m_src = g;
                if (mode) m_ptr = g;
            end else begin
                m_vld = 1'b0;
            end
        end
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
        chk({tag, ".out_data"},  32'(out_data),  32'(m_dat));
        chk({tag, ".out_src"},   32'(out_src),   32'(m_src));
        @(negedge clk);
    endtask

    initial begin
        m_vld = 1'b0; m_dat = '0; m_src = 0; m_ptr = N - 1;
        reset = 1'b1; in_valid = '1; mode = 1'b0; sel = '0; out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 8'hE0 + WIDTH'(i));

        // Reset with every channel valid
        cycle("rst0");
        chk("rst0.rdy_zero", 32'(rdy_seen), 32'h0);
        cycle("rst1");
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.out_data",  32'(out_data),  32'h00);
        chk("rst.out_src",   32'(out_src),   32'h0);

        // Fixed-mode streaming
        reset = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; set_ch(2, 8'hA5);
        cycle("fix");
        chk("fix.rdy", 32'(rdy_seen), 32'h4);
        chk("fix.data", 32'(out_data), 32'hA5);
        chk("fix.src",  32'(out_src),  32'h2);
        sel = 2'd3;
        cycle("fix_drain");
        chk("fix_drain.rdy", 32'(rdy_seen), 32'h0);
        chk("fix_drain.vld", 32'(out_valid), 32'h0);

        // Backpressure: held output ignores input churn
        sel = 2'd0; in_valid = 4'b0001; set_ch(0, 8'h3C);
        cycle("bp_load");
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sel = SEL_W'($urandom);
            in_valid = N'($urandom);
            in_data = $urandom;
            cycle("bp_hold");
            chk("bp_hold.data", 32'(out_data), 32'h3C);
            chk("bp_hold.rdy",  32'(rdy_seen), 32'h0);
        end
        out_ready = 1'b1; sel = 2'd1; in_valid = 4'b0010; set_ch(1, 8'h77);
        cycle("bp_release");
        chk("bp_release.rdy",  32'(rdy_seen), 32'h2);
        chk("bp_release.data", 32'(out_data), 32'h77);

        // Round-robin fairness, pointer still at N-1 from reset
        mode = 1'b1; in_valid = '1;
        for (int i = 0; i < N; i++) set_ch(i, 8'h10 + WIDTH'(i));
        for (int c = 0; c < 8; c++) begin
            cycle("rr_fair");
            chk("rr_fair.src",  32'(out_src),  32'(c % 4));
            chk("rr_fair.data", 32'(out_data), 32'(8'h10 + 8'(c % 4)));
        end

        // Skip and wrap from reset
        reset = 1'b1;
        cycle("rr_rst");
        reset = 1'b0; in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            cycle("rr_skip");
            chk("rr_skip.src", 32'(out_src), (c % 2 == 0) ? 32'h1 : 32'h3);
        end
        in_valid = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            cycle("rr_self");
            chk("rr_self.src", 32'(out_src), 32'h3);
        end

        // Mode switch keeps the pointer; mid-stall reset restarts the search at 0
        reset = 1'b1;
        cycle("ms_rst");
        reset = 1'b0; mode = 1'b1; in_valid = 4'b0100;
        cycle("ms_rr2");
        chk("ms_rr2.src", 32'(out_src), 32'h2);
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
        for (int c = 0; c < 3; c++) cycle("ms_fix");
        mode = 1'b1; in_valid = '1;
        cycle("ms_rr3");
        chk("ms_rr3.src", 32'(out_src), 32'h3);
        out_ready = 1'b0; reset = 1'b1;
        cycle("ms_rst_stall");
        chk("ms_rst_stall.vld", 32'(out_valid), 32'h0);
        chk("ms_rst_stall.src", 32'(out_src), 32'h0);
        reset = 1'b0; out_ready = 1'b1;
        cycle("ms_rr0");
        chk("ms_rr0.src", 32'(out_src), 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 49) == 0);
            mode      = 1'($urandom);
            sel       = SEL_W'($urandom);
            in_valid  = N'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_nway_mux_pipe.md
Name: pe_nway_mux_pipe

Overview:
Parametrised N-way, WIDTH-bit operand selector for the PE datapath, generalising the 2:1 byte mux. Adds two selection modes: fixed (external select) and round-robin arbitration among valid channels. Adds a registered output stage with valid/ready handshake on every input channel and on the output. Sits between the PE operand sources and the ALU input register.

Parameters:
WIDTH, 8, data bits per channel
N, 4, number of input channels (2..16)
SEL_W, 2, select/index width; must equal ceil(log2(N)), minimum 1

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel data valid
in_ready  output  N  per-channel accept; at most one bit high per cycle
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used when mode=0
out_data  output  WIDTH  registered selected data
out_src  output  SEL_W  index of the channel that produced out_data
out_valid  output  1  out_data/out_src valid
out_ready  input  1  downstream accept

Behaviour:
- Reset: out_valid=0, out_data=0, out_src=0, rr_ptr=N-1, so the first round-robin search starts at channel 0. Reset takes priority over any transfer in the same cycle. Reset mid-transfer drops held data; no in_ready is asserted that cycle.
- load_en = ~out_valid | out_ready. This is a single register stage with no skid buffer. in_ready is combinational from out_ready, out_valid, mode, sel, in_valid, and rr_ptr.
- Grant, mode=0:
  - g = sel if sel < N and in_valid[sel].
  - Otherwise no grant.
  - sel >= N never grants and never asserts in_ready.
- Grant, mode=1:
  - g = first i with in_valid[i]=1, searching rr_ptr+1, rr_ptr+2, … mod N.
  - No grant if all in_valid are 0.
- in_ready[g] = load_en when a grant exists. All other in_ready bits are 0.
- Transfer (posedge, load_en and grant):
  - out_data <= channel g
  - out_src <= g
  - out_valid <= 1
  - if mode=1: rr_ptr <= g
- Drain without load (load_en, no grant): out_valid <= 0. out_data and out_src hold their last values.
- Stall (out_valid=1, out_ready=0):
  - out_data, out_src, and out_valid are held.
  - All in_ready bits are 0.
  - rr_ptr is held.
  - Changes to mode/sel/in_data do not affect held output.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 transfer/cycle when out_ready is held high.
- rr_ptr changes only on a mode=1 transfer. Switching mode keeps rr_ptr, so fixed-mode traffic does not disturb fairness.
- Round-robin guarantee: a continuously valid channel is granted within N transfers.
- Wrap-around: with rr_ptr=N-1, the search begins at channel 0. With rr_ptr=k and only channel k valid, k is re-granted.
- Input data is sampled only at handshake. Input holding behaviour (in_valid/in_data stable until in_ready) is an upstream responsibility. The block does not check it.

Test Plan:
- Reset/idle: assert reset for 2 cycles with all in_valid=1 → out_valid=0, out_data=0x00, out_src=0, in_ready=0000 during reset.
- Fixed mode streaming:
  - Stimulus: mode=0, sel=2, ch2=0xA5 valid, out_ready=1.
  - Required: in_ready=0100 in the same cycle; next cycle out_data=0xA5, out_src=2, out_valid=1.
  - Then sel=3 with ch3 invalid → in_ready=0000; out_valid drops to 0 after the drain.
- Backpressure:
  - Stimulus: hold out_ready=0 after loading 0x3C; change sel and ch data for 5 cycles.
  - Required: out_data stays 0x3C, in_ready=0000.
  - Then raise out_ready with ch1=0x77 valid, sel=1 → same cycle in_ready=0010; next cycle out_data=0x77.
- Round-robin fairness: mode=1, all four channels valid, data 0x10..0x13, out_ready=1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3 with matching data.
- Round-robin skip and wrap:
  - Stimulus: mode=1, only ch3 and ch1 valid, starting from reset.
  - Required: grants 1,3,1,3.
  - Then only ch3 valid → grants 3,3 (self re-grant).
- Mode switch and mid-operation reset:
  - Stimulus: after RR grant to ch2, run 3 fixed-mode transfers with sel=0, then return to mode=1 with all valid.
  - Required: next RR grant is ch3 (rr_ptr held).
  - Then assert reset while out_valid=1, out_ready=0 → next cycle out_valid=0, out_src=0, and the following RR grant is ch0.
